hidden_weight_loader: RTL

//  Streams the 65 trained 10-bit weights (5 hidden neurons x 10 inputs, then 3 output

---
 rtl/hidden_weight_loader.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/hidden_weight_loader.sv
// hidden_weight_loader
// Writer side of the hidden-layer weight interface. Accepts N_WEIGHTS words from a
// valid/ready stream. Each accepted word is written to the next contiguous address one
// cycle later. The layer's run_en is raised once a complete set has been written.
// Optional build macro: CHECKSUM_EN. When defined, a 16-bit running sum of the accepted
// words is compared with exp_sum at the end of a load. A mismatch sets err and keeps
// run_en low.
module hidden_weight_loader #(
  parameter int DATA_W    = 10,
  parameter int N_WEIGHTS = 65,
  parameter int ADDR_W    = 7
) (
  input  logic              Clock,
  input  logic              Rst,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [15:0]       exp_sum,
  output logic              WE,
  output logic [ADDR_W-1:0] wAddr,
  output logic [DATA_W-1:0] wData,
  output logic              busy,
  output logic              done,
  output logic              run_en,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WEIGHTS - 1);

  state_t            state_r;
  state_t            nextState_s;
  logic [ADDR_W-1:0] count_r;
  logic [ADDR_W-1:0] countNext_s;
  logic              accept_s;
  logic              startOk_s;
  logic              mismatch_s;
  logic              sReadyNext_s;
  logic              weNext_s;
  logic              busyNext_s;
  logic              doneNext_s;
  logic              runEnNext_s;
  logic [ADDR_W-1:0] wAddrNext_s;
  logic [DATA_W-1:0] wDataNext_s;

  // s_ready is high exactly while in LOAD, so a beat is a valid word seen during LOAD
  assign accept_s  = s_valid & s_ready;
  // abort outranks start when both arrive in IDLE
  assign startOk_s = (state_r == IDLE) & start & ~abort;

`ifdef CHECKSUM_EN
  logic [15:0] sum_r;
  logic [15:0] expSum_r;
  logic        err_r;

  function automatic logic [15:0] sumAdd(input logic [15:0] acc, input logic [DATA_W-1:0] word);
    return acc + 16'(word);
  endfunction

  assign mismatch_s = (sum_r != expSum_r);
  assign err        = err_r;

  // Running sum of accepted words; the expected sum is captured with the start that opens the load
  always_ff @(posedge Clock) begin
    if (Rst) begin
      sum_r    <= 16'd0;
      expSum_r <= 16'd0;
    end else if (startOk_s) begin
      sum_r    <= 16'd0;
      expSum_r <= exp_sum;
    end else if (accept_s) begin
      sum_r    <= sumAdd(sum_r, s_data);
      expSum_r <= expSum_r;
    end else begin
      sum_r    <= sum_r;
      expSum_r <= expSum_r;
    end
  end

  // Checksum verdict is taken in the DONE cycle and cleared by the next accepted start
  always_ff @(posedge Clock) begin
    if (Rst) begin
      err_r <= 1'b0;
    end else if (startOk_s) begin
      err_r <= 1'b0;
    end else if (state_r == DONE) begin
      err_r <= mismatch_s;
    end else begin
      err_r <= err_r;
    end
  end
`else
  logic unusedExpSum_s;
  assign unusedExpSum_s = ^exp_sum;
  assign mismatch_s     = 1'b0;
  assign err            = 1'b0;
`endif

  // State register
  always_ff @(posedge Clock) begin
    if (Rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Next-state decision; abort in LOAD outranks completion of the last beat
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (startOk_s) nextState_s = LOAD;
        else           nextState_s = IDLE;
      end
      LOAD: begin
        if (abort)                                    nextState_s = IDLE;
        else if (accept_s && (count_r == LAST_ADDR))  nextState_s = DONE;
        else                                          nextState_s = LOAD;
      end
      DONE:    nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // Next values of the registered outputs and the beat counter
  always_comb begin
    sReadyNext_s = (nextState_s == LOAD);
    busyNext_s   = (nextState_s == LOAD);
    doneNext_s   = (nextState_s == DONE);
    weNext_s     = accept_s;
    wAddrNext_s  = wAddr;
    wDataNext_s  = wData;
    countNext_s  = count_r;
    runEnNext_s  = run_en;

    if (accept_s) begin
      wAddrNext_s = count_r;
      wDataNext_s = s_data;
    end else begin
      wAddrNext_s = wAddr;
      wDataNext_s = wData;
    end

    if (startOk_s) begin
      countNext_s = {ADDR_W{1'b0}};
      runEnNext_s = 1'b0;
    end else if (accept_s) begin
      countNext_s = count_r + ADDR_W'(1);
      runEnNext_s = run_en;
    end else if (state_r == DONE) begin
      countNext_s = count_r;
      runEnNext_s = ~mismatch_s;
    end else begin
      countNext_s = count_r;
      runEnNext_s = run_en;
    end
  end

  // Output and counter registers
  always_ff @(posedge Clock) begin
    if (Rst) begin
      count_r <= {ADDR_W{1'b0}};
      s_ready <= 1'b0;
      WE      <= 1'b0;
      wAddr   <= {ADDR_W{1'b0}};
      wData   <= {DATA_W{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      run_en  <= 1'b0;
    end else begin
      count_r <= countNext_s;
      s_ready <= sReadyNext_s;
      WE      <= weNext_s;
      wAddr   <= wAddrNext_s;
      wData   <= wDataNext_s;
      busy    <= busyNext_s;
      done    <= doneNext_s;
      run_en  <= runEnNext_s;
    end
  end

endmodule
